// File: rtl/con_pkg.sv
// con_pkg: shared types and constants for the convolution window controller.
// Build option: CON_WIN_ERR_EN adds the sticky err_sts status port to con_win_ctrl.
package con_pkg;

  // Controller phase: waiting for a frame, filling the first K-1 lines, or producing windows.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } con_state_e;

  // Default geometry.
  localparam int CON_LINE_W = 32;
  localparam int CON_K      = 7;
  localparam int CON_IDX_W  = 8;
  localparam int CON_ROW_W  = 10;

  // Counter width for a modulus n (at least one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/con_pos_cnt.sv
// con_pos_cnt: column / row / line-slot tracker for the incoming pixel stream.
// The pix_* outputs give the position the current pixel lands on (after any
// restart or line resync); the registers then step to the following position.
module con_pos_cnt
  import con_pkg::*;
#(
  parameter int LINE_W = CON_LINE_W,
  parameter int K      = CON_K,
  parameter int ROW_W  = CON_ROW_W,
  parameter int COL_W  = cnt_w(LINE_W),
  parameter int SLOT_W = cnt_w(K)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  input  logic              restart,
  input  logic              line_start,
  output logic [COL_W-1:0]  pix_col,
  output logic [ROW_W-1:0]  pix_row,
  output logic [SLOT_W-1:0] pix_slot,
  output logic [ROW_W-1:0]  row_nxt,
  output logic              resync
);

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(LINE_W - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(K - 1);
  localparam logic [ROW_W-1:0]  ROW_MAX   = {ROW_W{1'b1}};

  logic [COL_W-1:0]  col_r, col_nxt;
  logic [ROW_W-1:0]  row_r;
  logic [SLOT_W-1:0] slot_r, slot_nxt;

  // Row counter saturates so a very tall frame keeps producing windows.
  function automatic logic [ROW_W-1:0] row_inc(input logic [ROW_W-1:0] r);
    return (r == ROW_MAX) ? r : r + ROW_W'(1);
  endfunction

  // Line slots rotate through the K buffered lines.
  function automatic logic [SLOT_W-1:0] slot_inc(input logic [SLOT_W-1:0] s);
    return (s == SLOT_LAST) ? SLOT_W'(0) : s + SLOT_W'(1);
  endfunction

  // Position of the current pixel: restart wins, then a mid-line line_start resync.
  always_comb begin
    pix_col  = col_r;
    pix_row  = row_r;
    pix_slot = slot_r;
    resync   = 1'b0;
    if (restart) begin
      pix_col  = COL_W'(0);
      pix_row  = ROW_W'(0);
      pix_slot = SLOT_W'(0);
    end else if (line_start && (col_r != COL_W'(0))) begin
      resync   = 1'b1;
      pix_col  = COL_W'(0);
      pix_row  = row_inc(row_r);
      pix_slot = slot_inc(slot_r);
    end else begin
      resync   = 1'b0;
    end
  end

  // Position following the current pixel, with line wrap.
  always_comb begin
    col_nxt  = col_r;
    row_nxt  = row_r;
    slot_nxt = slot_r;
    if (adv) begin
      if (pix_col == COL_LAST) begin
        col_nxt  = COL_W'(0);
        row_nxt  = row_inc(pix_row);
        slot_nxt = slot_inc(pix_slot);
      end else begin
        col_nxt  = pix_col + COL_W'(1);
        row_nxt  = pix_row;
        slot_nxt = pix_slot;
      end
    end else begin
      col_nxt  = col_r;
      row_nxt  = row_r;
      slot_nxt = slot_r;
    end
  end

  // Position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r  <= COL_W'(0);
      row_r  <= ROW_W'(0);
      slot_r <= SLOT_W'(0);
    end else begin
      col_r  <= col_nxt;
      row_r  <= row_nxt;
      slot_r <= slot_nxt;
    end
  end

endmodule

// File: rtl/con_win_ctrl.sv
// con_win_ctrl: sequencing controller for the K-line circular convolution buffer.
// Generates the buffer write strobe/index, window-valid and the output framing
// strobes, all registered one cycle after the accepted pixel.
// Build option: CON_WIN_ERR_EN adds err_sts[1:0] (bit0 short frame, bit1 line resync).
module con_win_ctrl
  import con_pkg::*;
#(
  parameter int LINE_W = CON_LINE_W,
  parameter int K      = CON_K,
  parameter int IDX_W  = CON_IDX_W,
  parameter int ROW_W  = CON_ROW_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      frame_start_in,
  input  logic                      line_start_in,
  input  logic                      frame_end_in,
  output logic                      wr_en,
  output logic [IDX_W-1:0]          wr_idx,
  output logic [$clog2(K)-1:0]      oldest_slot,
  output logic [$clog2(LINE_W)-1:0] win_col,
  output logic                      out_valid,
  output logic                      frame_start_out,
  output logic                      line_start_out,
  output logic                      frame_end_out,
  output logic                      busy
`ifdef CON_WIN_ERR_EN
  ,
  output logic [1:0]                err_sts
`endif
);

  localparam int COL_W  = $clog2(LINE_W);
  localparam int SLOT_W = $clog2(K);
  localparam logic [ROW_W-1:0]  ROW_FULL  = ROW_W'(K - 1);
  localparam logic [COL_W-1:0]  COL_WIN   = COL_W'(K - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(K - 1);

  con_state_e        state_r, state_nxt;
  logic              accept_s, fend_s, valid_s, run_nxt_s;
  logic [IDX_W-1:0]  idx_s;
  logic [SLOT_W-1:0] oldest_s;
  logic [COL_W-1:0]  pix_col_s;
  logic [ROW_W-1:0]  pix_row_s, row_nxt_s;
  logic [SLOT_W-1:0] pix_slot_s;
  logic              resync_s;
  logic              first_pend_r;

  logic              wr_en_r, out_valid_r, fso_r, lso_r, feo_r, busy_r;
  logic [IDX_W-1:0]  wr_idx_r;
  logic [SLOT_W-1:0] oldest_r;
  logic [COL_W-1:0]  win_col_r;

  con_pos_cnt #(
    .LINE_W (LINE_W),
    .K      (K),
    .ROW_W  (ROW_W),
    .COL_W  (COL_W),
    .SLOT_W (SLOT_W)
  ) u_pos (
    .clk        (clk),
    .rst_n      (rst_n),
    .adv        (accept_s),
    .restart    (frame_start_in),
    .line_start (line_start_in),
    .pix_col    (pix_col_s),
    .pix_row    (pix_row_s),
    .pix_slot   (pix_slot_s),
    .row_nxt    (row_nxt_s),
    .resync     (resync_s)
  );

  // Pixel acceptance, window decode and next-state selection.
  always_comb begin
    accept_s  = enable && (frame_start_in || (state_r != IDLE));
    fend_s    = enable && frame_end_in;
    run_nxt_s = (row_nxt_s >= ROW_FULL);
    valid_s   = accept_s && (pix_row_s >= ROW_FULL) && (pix_col_s >= COL_WIN);
    idx_s     = IDX_W'(pix_slot_s) * IDX_W'(LINE_W) + IDX_W'(pix_col_s);
    if (pix_row_s >= ROW_FULL) begin
      oldest_s = (pix_slot_s == SLOT_LAST) ? SLOT_W'(0) : pix_slot_s + SLOT_W'(1);
    end else begin
      oldest_s = SLOT_W'(0);
    end
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (fend_s) begin
          state_nxt = IDLE;
        end else if (accept_s) begin
          state_nxt = run_nxt_s ? RUN : FILL;
        end else begin
          state_nxt = IDLE;
        end
      end
      FILL, RUN: begin
        if (fend_s) begin
          state_nxt = IDLE;
        end else if (accept_s) begin
          state_nxt = run_nxt_s ? RUN : FILL;
        end else begin
          state_nxt = state_r;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Registered outputs; address/column/slot hold their last value between pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_r      <= 1'b0;
      wr_idx_r     <= IDX_W'(0);
      oldest_r     <= SLOT_W'(0);
      win_col_r    <= COL_W'(0);
      out_valid_r  <= 1'b0;
      fso_r        <= 1'b0;
      lso_r        <= 1'b0;
      feo_r        <= 1'b0;
      busy_r       <= 1'b0;
      first_pend_r <= 1'b0;
    end else begin
      wr_en_r     <= accept_s;
      out_valid_r <= valid_s;
      fso_r       <= valid_s && first_pend_r;
      lso_r       <= valid_s && (pix_col_s == COL_WIN);
      feo_r       <= fend_s;
      busy_r      <= (state_nxt != IDLE);
      if (accept_s) begin
        wr_idx_r  <= idx_s;
        oldest_r  <= oldest_s;
        win_col_r <= pix_col_s;
      end
      // The first window of each frame is flagged once.
      if (accept_s && frame_start_in) begin
        first_pend_r <= 1'b1;
      end else if (valid_s) begin
        first_pend_r <= 1'b0;
      end
    end
  end

  assign wr_en           = wr_en_r;
  assign wr_idx          = wr_idx_r;
  assign oldest_slot     = oldest_r;
  assign win_col         = win_col_r;
  assign out_valid       = out_valid_r;
  assign frame_start_out = fso_r;
  assign line_start_out  = lso_r;
  assign frame_end_out   = feo_r;
  assign busy            = busy_r;

`ifdef CON_WIN_ERR_EN
  logic [1:0] err_r, err_nxt;

  // Sticky status: cleared by a new frame, set by early frame end or mid-line resync.
  always_comb begin
    err_nxt = err_r;
    if (accept_s) begin
      if (frame_start_in) begin
        err_nxt = 2'b00;
      end else begin
        err_nxt = err_r;
      end
      if (frame_end_in && (pix_row_s < ROW_FULL)) begin
        err_nxt[0] = 1'b1;
      end
      if (resync_s) begin
        err_nxt[1] = 1'b1;
      end
    end else begin
      err_nxt = err_r;
    end
  end

  // Status register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 2'b00;
    end else begin
      err_r <= err_nxt;
    end
  end

  assign err_sts = err_r;
`endif

endmodule

// File: tb/tb_con_win_ctrl.sv
// tb_con_win_ctrl: self-checking bench for con_win_ctrl (LINE_W=32, K=7).
module tb_con_win_ctrl;

  localparam int LW = 32;
  localparam int KK = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic       frame_start_in = 1'b0;
  logic       line_start_in = 1'b0;
  logic       frame_end_in = 1'b0;
  logic       wr_en;
  logic [7:0] wr_idx;
  logic [2:0] oldest_slot;
  logic [4:0] win_col;
  logic       out_valid, frame_start_out, line_start_out, frame_end_out, busy;
`ifdef CON_WIN_ERR_EN
  logic [1:0] err_sts;
`endif

  con_win_ctrl #(.LINE_W(LW), .K(KK), .IDX_W(8), .ROW_W(10)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .frame_start_in  (frame_start_in),
    .line_start_in   (line_start_in),
    .frame_end_in    (frame_end_in),
    .wr_en           (wr_en),
    .wr_idx          (wr_idx),
    .oldest_slot     (oldest_slot),
    .win_col         (win_col),
    .out_valid       (out_valid),
    .frame_start_out (frame_start_out),
    .line_start_out  (line_start_out),
    .frame_end_out   (frame_end_out),
    .busy            (busy)
`ifdef CON_WIN_ERR_EN
    ,
    .err_sts         (err_sts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       wr_en;
    logic [7:0] wr_idx;
    logic [2:0] old;
    logic [4:0] wcol;
    logic       ov;
    logic       fso;
    logic       lso;
    logic       feo;
    logic       busy;
  } exp_t;

  typedef struct {
    bit en, fs, ls, fe;
    bit e_wr_en;
    int e_idx;
    bit e_ov, e_busy, e_feo;
  } vec_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference model state (spec-level, integer arithmetic)
  int     m_state, m_col, m_row, m_slot, m_widx, m_wcol, m_old;
  bit     m_first;
  bit [1:0] m_err;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_col = 0; m_row = 0; m_slot = 0;
    m_widx = 0; m_wcol = 0; m_old = 0; m_first = 0; m_err = 2'b00;
  endtask

  task automatic model_push(input bit en, input bit fs, input bit ls, input bit fe);
    exp_t e;
    int pc, pr, ps;
    bit acc;
    e = '0; acc = 0; pc = m_col; pr = m_row; ps = m_slot;
    if (en && fs) begin
      acc = 1; pc = 0; pr = 0; ps = 0; m_first = 1; m_err = 2'b00;
    end else if (en && m_state != 0) begin
      acc = 1;
      if (ls && m_col != 0) begin
        pc = 0; pr = (m_row < 1023) ? m_row + 1 : m_row; ps = (m_slot + 1) % KK;
        m_err[1] = 1'b1;
      end
    end
    if (acc) begin
      m_widx = ps * LW + pc;
      m_wcol = pc;
      m_old  = (pr >= KK - 1) ? (ps + 1) % KK : 0;
      e.wr_en = 1'b1;
      e.ov  = (pr >= KK - 1) && (pc >= KK - 1);
      e.fso = e.ov && m_first;
      if (e.ov) m_first = 0;
      e.lso = e.ov && (pc == KK - 1);
      if (fe && pr < KK - 1) m_err[0] = 1'b1;
      if (pc == LW - 1) begin
        m_col = 0; m_row = (pr < 1023) ? pr + 1 : pr; m_slot = (ps + 1) % KK;
      end else begin
        m_col = pc + 1; m_row = pr; m_slot = ps;
      end
      m_state = (m_row >= KK - 1) ? 2 : 1;
    end
    if (en && fe) begin
      e.feo = 1'b1; m_state = 0;
    end
    e.wr_idx = 8'(m_widx);
    e.old    = 3'(m_old);
    e.wcol   = 5'(m_wcol);
    e.busy   = (m_state != 0);
    sb_q.push_back(e);
  endtask

  task automatic check_sb();
    exp_t e, a;
    n_chk++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: queue empty, got output %h", {wr_en, wr_idx});
    end else begin
      e = sb_q.pop_front();
      a = {wr_en, wr_idx, oldest_slot, win_col, out_valid,
           frame_start_out, line_start_out, frame_end_out, busy};
      if (a !== e) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t: got we=%b idx=%0d old=%0d col=%0d ov=%b fso=%b lso=%b feo=%b busy=%b expected we=%b idx=%0d old=%0d col=%0d ov=%b fso=%b lso=%b feo=%b busy=%b",
                 $time, a.wr_en, a.wr_idx, a.old, a.wcol, a.ov, a.fso, a.lso, a.feo, a.busy,
                 e.wr_en, e.wr_idx, e.old, e.wcol, e.ov, e.fso, e.lso, e.feo, e.busy);
      end
    end
  endtask

  task automatic step(input bit en, input bit fs, input bit ls, input bit fe);
    enable = en; frame_start_in = fs; line_start_in = ls; frame_end_in = fe;
    model_push(en, fs, ls, fe);
    @(posedge clk);
    #1;
    check_sb();
  endtask

  task automatic check_all_zero(input string nm);
    chk(nm, int'({wr_en, wr_idx, oldest_slot, win_col, out_valid,
                  frame_start_out, line_start_out, frame_end_out}), 0);
    chk({nm, "_busy"}, int'(busy), 0);
`ifdef CON_WIN_ERR_EN
    chk({nm, "_err"}, int'(err_sts), 0);
`endif
  endtask

  task automatic hard_reset();
    enable = 0; frame_start_in = 0; line_start_in = 0; frame_end_in = 0;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_outputs");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    sb_q.delete();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[15];
    int ov_cnt, lso_cnt, first_ov, fso_idx, pix;

    #2;
    hard_reset();

    // ---------------- table-driven vectors ----------------
    tbl[0]  = '{1,0,0,0, 0,  0, 0,0,0};
    tbl[1]  = '{0,1,0,0, 0,  0, 0,0,0};
    tbl[2]  = '{1,1,0,0, 1,  0, 0,1,0};
    tbl[3]  = '{1,0,0,0, 1,  1, 0,1,0};
    tbl[4]  = '{0,0,0,0, 0,  1, 0,1,0};
    tbl[5]  = '{1,0,1,0, 1, 32, 0,1,0};
    tbl[6]  = '{1,0,0,0, 1, 33, 0,1,0};
    tbl[7]  = '{1,0,0,1, 1, 34, 0,0,1};
    tbl[8]  = '{1,0,0,0, 0, 34, 0,0,0};
    tbl[9]  = '{1,1,0,1, 1,  0, 0,0,1};
    tbl[10] = '{1,0,1,0, 0,  0, 0,0,0};
    tbl[11] = '{1,1,1,0, 1,  0, 0,1,0};
    tbl[12] = '{1,0,1,0, 1, 32, 0,1,0};
    tbl[13] = '{1,0,1,0, 1, 64, 0,1,0};
    tbl[14] = '{1,0,1,1, 1, 96, 0,0,1};
    for (int i = 0; i < 15; i++) begin
      enable = tbl[i].en; frame_start_in = tbl[i].fs;
      line_start_in = tbl[i].ls; frame_end_in = tbl[i].fe;
      @(posedge clk);
      #1;
      n_chk++;
      if ({wr_en, wr_idx, out_valid, busy, frame_end_out} !==
          {tbl[i].e_wr_en, 8'(tbl[i].e_idx), tbl[i].e_ov, tbl[i].e_busy, tbl[i].e_feo}) begin
        n_fail++;
        $display("FAIL vec%0d: got we=%b idx=%0d ov=%b busy=%b feo=%b expected we=%b idx=%0d ov=%b busy=%b feo=%b",
                 i, wr_en, wr_idx, out_valid, busy, frame_end_out,
                 tbl[i].e_wr_en, tbl[i].e_idx, tbl[i].e_ov, tbl[i].e_busy, tbl[i].e_feo);
      end
    end

    // ---------------- full frame, 10 lines ----------------
    hard_reset();
    ov_cnt = 0; lso_cnt = 0; first_ov = -1; fso_idx = -1;
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < LW; c++) begin
        pix = r * LW + c;
        step(1, (r == 0 && c == 0), (c == 0), (r == 9 && c == LW - 1));
        if (out_valid) begin
          ov_cnt++;
          if (first_ov < 0) first_ov = pix;
        end
        if (frame_start_out) fso_idx = pix;
        if (line_start_out) lso_cnt++;
        if (pix == 223) chk("wrap_idx223", int'(wr_idx), 223);
        if (pix == 224) begin
          chk("wrap_idx0", int'(wr_idx), 0);
          chk("wrap_oldest", int'(oldest_slot), 1);
        end
      end
    end
    chk("frame_end_out_last", int'(frame_end_out), 1);
    chk("first_valid_pixel", first_ov, 6 * LW + 6);
    chk("frame_start_out_pixel", fso_idx, 6 * LW + 6);
    chk("out_valid_count", ov_cnt, 104);
    chk("line_start_out_count", lso_cnt, 4);
    step(0, 0, 0, 0);
    chk("idle_after_frame", int'({busy, frame_end_out}), 0);

    // ---------------- short frame ----------------
    hard_reset();
    ov_cnt = 0;
    for (int i = 0; i < 2 * LW + 5; i++) begin
      step(1, (i == 0), (i % LW == 0), (i == 2 * LW + 4));
      if (out_valid) ov_cnt++;
    end
    chk("short_no_valid", ov_cnt, 0);
    chk("short_feo", int'(frame_end_out), 1);
    chk("short_busy", int'(busy), 0);
`ifdef CON_WIN_ERR_EN
    chk("short_err", int'(err_sts), 1);
`endif

    // ---------------- line resync ----------------
    hard_reset();
    for (int i = 0; i < 2 * LW + 20; i++) step(1, (i == 0), 1'b0, 1'b0);
    step(1, 0, 1, 0);
    chk("resync_idx", int'(wr_idx), 96);
`ifdef CON_WIN_ERR_EN
    chk("resync_err", int'(err_sts), 2);
`endif
    step(1, 0, 0, 0);
    chk("resync_next_idx", int'(wr_idx), 97);
    step(1, 0, 0, 1);

    // ---------------- restart mid-RUN with enable gaps ----------------
    hard_reset();
    for (int i = 0; i <= 7 * LW + 10; i++) begin
      if (i % 7 == 3) step(0, 0, 0, 0);
      step(1, (i == 0), 1'b0, 1'b0);
    end
    chk("run_valid", int'(out_valid), 1);
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("restart_idx", int'(wr_idx), 0);
    chk("restart_valid_drop", int'(out_valid), 0);
    chk("restart_busy", int'(busy), 1);
    step(1, 0, 0, 0);
    chk("restart_fill_idx", int'(wr_idx), 1);

    // ---------------- reset mid-RUN ----------------
    for (int i = 0; i < 7 * LW + 8; i++) step(1, 0, 0, 0);
    chk("pre_reset_valid", int'(out_valid), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    sb_q.delete();
    for (int i = 0; i < 3; i++) step(1, 0, (i == 1), 0);
    chk("post_reset_dropped", int'({wr_en, busy}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
